// File: rtl/gpio_pad_ctrl_if.sv
// rtl/gpio_pad_ctrl_if.sv - configuration write port of the GPIO pad controller
interface gpio_pad_ctrl_if #(
  parameter int DEB_W = 4
);
  logic             cfg_we;
  logic             cfg_dir;
  logic [1:0]       cfg_pull;
  logic             cfg_schmitt;
  logic             cfg_slew;
  logic [DEB_W-1:0] cfg_deb;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_dir, cfg_pull, cfg_schmitt, cfg_slew, cfg_deb,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_dir, cfg_pull, cfg_schmitt, cfg_slew, cfg_deb,
    output cfg_err
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// rtl/gpio_pad_ctrl.sv - GPIO pad controller: config shadow, direction turnaround, input sync and debounce
module gpio_pad_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 2,
  parameter int DEB_W       = 4
) (
  input  logic           clk,
  input  logic           rst,
  gpio_pad_ctrl_if.slave cfg,
  input  logic           dout,
  output logic           din,
  output logic           rise,
  output logic           fall,
  output logic           busy,
  output logic           pad_a,
  output logic           pad_oe,
  output logic           pad_ie,
  output logic           pad_pu,
  output logic           pad_pd,
  output logic           pad_cs,
  output logic           pad_sl,
  input  logic           pad_y
);

  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC);

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       turn_q;
  logic [3:0]       turn_d;

  logic             sh_dir;
  logic [1:0]       sh_pull;
  logic [DEB_W-1:0] sh_deb;

  logic             cfg_load;
  logic             dir_d;
  logic [1:0]       pull_d;

  logic             oe_d;
  logic             ie_d;
  logic             pu_d;
  logic             pd_d;
  logic             busy_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [DEB_W:0]         deb_q;
  logic                   deb_active;

  // Writes are only taken while no turnaround is running; the decoded
  // direction/pull below are the values the shadow holds after this edge.
  assign cfg_load = cfg.cfg_we & ~busy;
  assign dir_d    = cfg_load ? cfg.cfg_dir  : sh_dir;
  assign pull_d   = cfg_load ? cfg.cfg_pull : sh_pull;
  assign sync_s   = sync_q[SYNC_STAGES-1];

  // Debounce only runs while the pad stays an input across this edge, so
  // no DIN change or edge pulse ever lands outside IN.
  assign deb_active = (state_q == ST_IN) && (state_d == ST_IN);

  // Next-state and registered-pin decode; pad pins follow the state being entered
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    oe_d    = 1'b0;
    ie_d    = 1'b0;
    pu_d    = 1'b0;
    pd_d    = 1'b0;
    busy_d  = 1'b1;

    case (state_q)
      ST_IN: begin
        if (dir_d) begin
          state_d = ST_TURN_OUT;
          turn_d  = TURN_LOAD;
        end
      end
      ST_OUT: begin
        if (!dir_d) begin
          state_d = ST_TURN_IN;
          turn_d  = TURN_LOAD;
        end
      end
      ST_TURN_OUT: begin
        if (turn_q <= 4'd1) state_d = ST_OUT;
        else                turn_d  = turn_q - 4'd1;
      end
      ST_TURN_IN: begin
        if (turn_q <= 4'd1) state_d = ST_IN;
        else                turn_d  = turn_q - 4'd1;
      end
      default: begin
        state_d = ST_TURN_IN;
        turn_d  = TURN_LOAD;
      end
    endcase

    case (state_d)
      ST_IN: begin
        ie_d   = 1'b1;
        busy_d = 1'b0;
        case (pull_d)
          2'b01: pd_d = 1'b1;
          2'b10: pu_d = 1'b1;
          2'b11: begin
            // keeper reinforces the level DIN already holds
            pu_d = din;
            pd_d = ~din;
          end
          default: ;
        endcase
      end
      ST_OUT: begin
        oe_d   = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State, turnaround count and pad control pins; reset parks in a full TURN_IN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_TURN_IN;
      turn_q  <= TURN_LOAD;
      pad_oe  <= 1'b0;
      pad_ie  <= 1'b0;
      pad_pu  <= 1'b0;
      pad_pd  <= 1'b0;
      busy    <= 1'b1;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      pad_oe  <= oe_d;
      pad_ie  <= ie_d;
      pad_pu  <= pu_d;
      pad_pd  <= pd_d;
      busy    <= busy_d;
    end
  end

  // Config shadow; schmitt and slew shadows drive CS/SL directly; dropped writes flag an error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_dir      <= 1'b0;
      sh_pull     <= 2'b00;
      sh_deb      <= '0;
      pad_cs      <= 1'b0;
      pad_sl      <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= cfg.cfg_we & busy;
      if (cfg_load) begin
        sh_dir  <= cfg.cfg_dir;
        sh_pull <= cfg.cfg_pull;
        sh_deb  <= cfg.cfg_deb;
        pad_cs  <= cfg.cfg_schmitt;
        pad_sl  <= cfg.cfg_slew;
      end
    end
  end

  // Core output data reaches the pad one cycle later in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pad_a <= 1'b0;
    else     pad_a <= dout;
  end

  // Plain flop chain bringing the asynchronous pad input into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad_y};
  end

  // Debounce: accept S once it has differed from DIN for sh_deb+1 consecutive cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      din   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!deb_active || (sync_s == din)) begin
        deb_q <= '0;
      end else if (deb_q >= {1'b0, sh_deb}) begin
        // saturating compare: a limit lowered mid-count fires on the next cycle
        din   <= sync_s;
        rise  <= sync_s;
        fall  <= ~sync_s;
        deb_q <= '0;
      end else begin
        deb_q <= deb_q + (DEB_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb/tb_gpio_pad_ctrl.sv - self-checking bench for gpio_pad_ctrl
module tb_gpio_pad_ctrl;
  localparam int SYNC_STAGES = 2;
  localparam int TURN_CYC    = 2;
  localparam int DEB_W       = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dout = 1'b0;
  logic pad_y = 1'b0;
  logic din, rise, fall, busy;
  logic pad_a, pad_oe, pad_ie, pad_pu, pad_pd, pad_cs, pad_sl;

  int checks = 0;
  int errors = 0;

  gpio_pad_ctrl_if #(.DEB_W(DEB_W)) cfg_bus();

  gpio_pad_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .TURN_CYC(TURN_CYC),
    .DEB_W(DEB_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg(cfg_bus),
    .dout(dout),
    .din(din),
    .rise(rise),
    .fall(fall),
    .busy(busy),
    .pad_a(pad_a),
    .pad_oe(pad_oe),
    .pad_ie(pad_ie),
    .pad_pu(pad_pu),
    .pad_pd(pad_pd),
    .pad_cs(pad_cs),
    .pad_sl(pad_sl),
    .pad_y(pad_y)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_pu(input logic [1:0] pl, input logic d);
    return (pl == 2'b10) || (pl == 2'b11 && d);
  endfunction

  function automatic logic exp_pd(input logic [1:0] pl, input logic d);
    return (pl == 2'b01) || (pl == 2'b11 && !d);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dout = 1'b0;
    pad_y = 1'b0;
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_dir = 1'b0;
    cfg_bus.cfg_pull = 2'b00;
    cfg_bus.cfg_schmitt = 1'b0;
    cfg_bus.cfg_slew = 1'b0;
    cfg_bus.cfg_deb = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (TURN_CYC) tick();
  endtask

  task automatic write_cfg(input logic dir, input logic [1:0] pl, input logic sch,
                           input logic sl, input logic [DEB_W-1:0] deb);
    cfg_bus.cfg_we = 1'b1;
    cfg_bus.cfg_dir = dir;
    cfg_bus.cfg_pull = pl;
    cfg_bus.cfg_schmitt = sch;
    cfg_bus.cfg_slew = sl;
    cfg_bus.cfg_deb = deb;
    tick();
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    #1 rst = 1'b1;
    #1;
    got = {pad_oe, pad_ie, pad_pu, pad_pd, pad_a, pad_cs, pad_sl, busy, din, rise, fall, cfg_bus.cfg_err};
    checks++;
    if (got !== 12'h010) begin
      $display("FAIL reset_immediate: got %b want %b", got, 12'h010);
      errors++;
    end
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_dir = 1'b0;
    cfg_bus.cfg_pull = 2'b00;
    cfg_bus.cfg_schmitt = 1'b0;
    cfg_bus.cfg_slew = 1'b0;
    cfg_bus.cfg_deb = '0;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= TURN_CYC + 2; e++) begin
      tick();
      got = {pad_oe, pad_ie, pad_pu, pad_pd, pad_a, pad_cs, pad_sl, busy, din, rise, fall, cfg_bus.cfg_err};
      exp = 12'h000;
      exp[10] = (e >= TURN_CYC);
      exp[4] = (e < TURN_CYC);
      checks++;
      if (got !== exp) begin
        $display("FAIL reset_release edge %0d: got %b want %b", e, got, exp);
        errors++;
      end
    end
  endtask

  task automatic test_cfg_err();
    logic sch, sl, prev_a;
    do_reset();
    sch = 1'($urandom_range(1, 0));
    sl = 1'($urandom_range(1, 0));
    dout = 1'($urandom_range(1, 0));
    prev_a = dout;
    write_cfg(1'b1, 2'b10, sch, sl, 4'd0);
    checks++;
    if ({pad_oe, pad_ie, pad_pu, pad_pd, busy, pad_cs, pad_sl, pad_a} !== {4'b0000, 1'b1, sch, sl, prev_a}) begin
      $display("FAIL dir_out_n: got %b want %b",
               {pad_oe, pad_ie, pad_pu, pad_pd, busy, pad_cs, pad_sl, pad_a}, {4'b0000, 1'b1, sch, sl, prev_a});
      errors++;
    end
    dout = 1'($urandom_range(1, 0));
    prev_a = dout;
    write_cfg(1'b0, 2'b01, ~sch, ~sl, 4'd7);
    checks++;
    if ({pad_oe, busy, cfg_bus.cfg_err, pad_cs, pad_sl, pad_a} !== {1'b0, 1'b1, 1'b1, sch, sl, prev_a}) begin
      $display("FAIL cfg_err_pulse: got %b want %b",
               {pad_oe, busy, cfg_bus.cfg_err, pad_cs, pad_sl, pad_a}, {1'b0, 1'b1, 1'b1, sch, sl, prev_a});
      errors++;
    end
    for (int k = 0; k < 10; k++) begin
      dout = 1'($urandom_range(1, 0));
      prev_a = dout;
      tick();
      checks++;
      if ({pad_oe, pad_ie, pad_pu, pad_pd, busy, cfg_bus.cfg_err, pad_cs, pad_sl, pad_a} !==
          {5'b10000, 1'b0, sch, sl, prev_a}) begin
        $display("FAIL out_hold cyc %0d: got %b want %b", k,
                 {pad_oe, pad_ie, pad_pu, pad_pd, busy, cfg_bus.cfg_err, pad_cs, pad_sl, pad_a},
                 {5'b10000, 1'b0, sch, sl, prev_a});
        errors++;
      end
    end
  endtask

  task automatic run_turn(input logic to_out);
    logic sch, sl;
    logic [1:0] pl;
    logic [6:0] got, exp;
    sch = 1'($urandom_range(1, 0));
    sl = 1'($urandom_range(1, 0));
    pl = 2'($urandom_range(3, 0));
    write_cfg(to_out, pl, sch, sl, 4'd0);
    for (int j = 0; j <= TURN_CYC; j++) begin
      got = {pad_oe, pad_ie, pad_pu, pad_pd, busy, pad_cs, pad_sl};
      exp = {1'b0, 1'b0, 1'b0, 1'b0, (j < TURN_CYC), sch, sl};
      if (j == TURN_CYC) begin
        exp[6] = to_out;
        exp[5] = !to_out;
        exp[4] = !to_out && exp_pu(pl, 1'b0);
        exp[3] = !to_out && exp_pd(pl, 1'b0);
      end
      checks++;
      if (got !== exp) begin
        $display("FAIL turn to_out=%0b step %0d: got %b want %b", to_out, j, got, exp);
        errors++;
      end
      if (j < TURN_CYC) tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      run_turn(1'b1);
      run_turn(1'b0);
    end
  endtask

  task automatic test_pull();
    logic [1:0] pl;
    logic sch, sl;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      pl = 2'($urandom_range(3, 0));
      sch = 1'($urandom_range(1, 0));
      sl = 1'($urandom_range(1, 0));
      write_cfg(1'b0, pl, sch, sl, 4'($urandom_range(15, 0)));
      checks++;
      if ({pad_oe, pad_ie, busy, pad_pu, pad_pd, pad_cs, pad_sl} !==
          {3'b010, exp_pu(pl, 1'b0), exp_pd(pl, 1'b0), sch, sl}) begin
        $display("FAIL pull pl=%b: got %b want %b", pl,
                 {pad_oe, pad_ie, busy, pad_pu, pad_pd, pad_cs, pad_sl},
                 {3'b010, exp_pu(pl, 1'b0), exp_pd(pl, 1'b0), sch, sl});
        errors++;
      end
    end
  endtask

  task automatic test_debounce();
    logic [2:0] got, exp;
    do_reset();
    write_cfg(1'b0, 2'b00, 1'b0, 1'b0, 4'd3);
    pad_y = 1'b1;
    for (int e = 1; e <= SYNC_STAGES + 6; e++) begin
      tick();
      got = {din, rise, fall};
      exp = {(e >= SYNC_STAGES + 4), (e == SYNC_STAGES + 4), 1'b0};
      checks++;
      if (got !== exp) begin
        $display("FAIL deb3_rise edge %0d: got %b want %b", e, got, exp);
        errors++;
      end
    end
    pad_y = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) pad_y = 1'b1;
      checks++;
      if ({din, rise, fall} !== 3'b100) begin
        $display("FAIL deb3_glitch edge %0d: got %b want %b", e, {din, rise, fall}, 3'b100);
        errors++;
      end
    end
  endtask

  task automatic test_deb_max();
    do_reset();
    write_cfg(1'b0, 2'b00, 1'b0, 1'b0, 4'd15);
    pad_y = 1'b1;
    for (int e = 1; e <= SYNC_STAGES + 18; e++) begin
      tick();
      checks++;
      if ({din, rise} !== {(e >= SYNC_STAGES + 16), (e == SYNC_STAGES + 16)}) begin
        $display("FAIL deb15 edge %0d: got %b want %b", e, {din, rise},
                 {(e >= SYNC_STAGES + 16), (e == SYNC_STAGES + 16)});
        errors++;
      end
    end
  endtask

  task automatic test_deb_change();
    do_reset();
    write_cfg(1'b0, 2'b00, 1'b0, 1'b0, 4'd5);
    pad_y = 1'b1;
    repeat (4) tick();
    write_cfg(1'b0, 2'b00, 1'b0, 1'b0, 4'd1);
    checks++;
    if (din !== 1'b0) begin
      $display("FAIL deb_change_load: got %b want 0", din);
      errors++;
    end
    tick();
    checks++;
    if ({din, rise} !== 2'b11) begin
      $display("FAIL deb_change_apply: got %b want 11", {din, rise});
      errors++;
    end
  endtask

  task automatic test_keeper();
    do_reset();
    write_cfg(1'b0, 2'b11, 1'b0, 1'b0, 4'd0);
    pad_y = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if ({din, pad_pu, pad_pd} !== {(e >= SYNC_STAGES + 1), (e >= SYNC_STAGES + 2), (e < SYNC_STAGES + 2)}) begin
        $display("FAIL keeper edge %0d: got %b want %b", e, {din, pad_pu, pad_pd},
                 {(e >= SYNC_STAGES + 1), (e >= SYNC_STAGES + 2), (e < SYNC_STAGES + 2)});
        errors++;
      end
    end
    write_cfg(1'b1, 2'b11, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({pad_pu, pad_pd, busy, pad_oe, din} !== 5'b00101) begin
      $display("FAIL keeper_to_out: got %b want %b", {pad_pu, pad_pd, busy, pad_oe, din}, 5'b00101);
      errors++;
    end
  endtask

  task automatic test_deb_random();
    logic pyh[0:255];
    logic din_m, s_b, prev_din, er, ef;
    int run;
    int deb;
    logic [1:0] pl;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      pl = 2'(r);
      deb = $urandom_range(4, 0);
      write_cfg(1'b0, pl, 1'b0, 1'b0, 4'(deb));
      din_m = 1'b0;
      run = 0;
      for (int k = 0; k < 200; k++) begin
        if (k == 0) pyh[k] = 1'b0;
        else if ($urandom_range(3, 0) == 0) pyh[k] = ~pyh[k-1];
        else pyh[k] = pyh[k-1];
        pad_y = pyh[k];
        dout = 1'($urandom_range(1, 0));
        tick();
        s_b = (k >= SYNC_STAGES) ? pyh[k-SYNC_STAGES] : 1'b0;
        prev_din = din_m;
        er = 1'b0;
        ef = 1'b0;
        if (s_b != din_m) begin
          run++;
          if (run == deb + 1) begin
            din_m = s_b;
            er = s_b;
            ef = !s_b;
            run = 0;
          end
        end else begin
          run = 0;
        end
        checks++;
        if ({din, rise, fall, pad_pu, pad_pd, pad_ie, pad_a} !==
            {din_m, er, ef, exp_pu(pl, prev_din), exp_pd(pl, prev_din), 1'b1, dout}) begin
          $display("FAIL deb_random pl=%b deb=%0d k=%0d: got %b want %b", pl, deb, k,
                   {din, rise, fall, pad_pu, pad_pd, pad_ie, pad_a},
                   {din_m, er, ef, exp_pu(pl, prev_din), exp_pd(pl, prev_din), 1'b1, dout});
          errors++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    do_reset();
    dout = 1'b1;
    write_cfg(1'b1, 2'b10, 1'b1, 1'b1, 4'd0);
    tick();
    #2 rst = 1'b1;
    #1;
    got = {pad_oe, pad_ie, pad_pu, pad_pd, pad_a, pad_cs, pad_sl, busy, din, rise, fall, cfg_bus.cfg_err};
    checks++;
    if (got !== 12'h010) begin
      $display("FAIL reset_mid_immediate: got %b want %b", got, 12'h010);
      errors++;
    end
    tick();
    rst = 1'b0;
    for (int e = 1; e <= TURN_CYC + 2; e++) begin
      tick();
      checks++;
      if ({pad_oe, pad_ie, pad_pu, pad_pd, pad_cs, pad_sl, busy} !==
          {1'b0, (e >= TURN_CYC), 4'b0000, (e < TURN_CYC)}) begin
        $display("FAIL reset_mid_release edge %0d: got %b want %b", e,
                 {pad_oe, pad_ie, pad_pu, pad_pd, pad_cs, pad_sl, busy},
                 {1'b0, (e >= TURN_CYC), 4'b0000, (e < TURN_CYC)});
        errors++;
      end
    end
  endtask

  initial begin
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_dir = 1'b0;
    cfg_bus.cfg_pull = 2'b00;
    cfg_bus.cfg_schmitt = 1'b0;
    cfg_bus.cfg_slew = 1'b0;
    cfg_bus.cfg_deb = '0;
    test_reset();
    test_cfg_err();
    test_back_to_back();
    test_pull();
    test_debounce();
    test_deb_max();
    test_deb_change();
    test_keeper();
    test_deb_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
